// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: FSM state encoding and reset values shared by the divider
package seq_divider_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_FLAG  = 1'b0;

endpackage

// File: rtl/fulladder.sv
// fulladder: single-bit full adder cell used to build ripple datapaths
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_sub.sv
// rca_sub: N-bit ripple-borrow subtractor computing a + ~b + 1 from fulladder cells
module rca_sub #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] c;

    assign c[0] = 1'b1;

    genvar i;
    for (i = 0; i < N; i++) begin : g_fa
        fulladder u_fa (
            .a    (a[i]),
            .b    (~b[i]),
            .cin  (c[i]),
            .s    (diff[i]),
            .cout (c[i+1])
        );
    end

    // a carry out of the top stage means a >= b, i.e. no borrow
    assign borrow = ~c[N];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per cycle, valid/ready on both sides
// Optional signed (two's complement, truncate toward zero) operation: define SEQ_DIVIDER_SIGNED_EN
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             diff_msb_unused;
    logic [WIDTH-1:0] r_nx, q_nx;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             accept;

    // {R,Q} shifted left by one; R's new LSB is the next dividend bit
    assign shl = {r_q, q_q[WIDTH-1]};

    rca_sub #(.N(WIDTH+1)) u_sub (
        .a      (shl),
        .b      ({1'b0, dvs_q}),
        .diff   (diff),
        .borrow (borrow)
    );

    // when no borrow the difference is below the divisor, so its MSB is always zero
    assign diff_msb_unused = diff[WIDTH];
    assign r_nx = borrow ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_nx = {q_q[WIDTH-2:0], ~borrow};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q, neg_d;
    logic rneg_q, rneg_d;

    assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
    assign q_fix = neg_q ? -q_nx : q_nx;
    assign r_fix = rneg_q ? -r_nx : r_nx;

    // capture result signs at accept: quotient sign from both operands, remainder follows dividend
    always_comb begin
        neg_d  = accept ? dividend[WIDTH-1] ^ divisor[WIDTH-1] : neg_q;
        rneg_d = accept ? dividend[WIDTH-1] : rneg_q;
    end

    // sign flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q  <= RST_FLAG;
            rneg_q <= RST_FLAG;
        end else begin
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fix = q_nx;
    assign r_fix = r_nx;
`endif

    assign in_ready    = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept      = in_valid & in_ready;
    assign out_valid   = state_q == DONE;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

    // next-state and datapath: accept from IDLE/DONE, iterate in BUSY, hold results in DONE
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        if (state_q == DONE && out_ready)
            state_d = IDLE;
        if (accept) begin
            dvs_d = b_mag;
            r_d   = '0;
            q_d   = a_mag;
            cnt_d = CW'(WIDTH - 1);
            if (divisor == '0) begin
                state_d = DONE;
                quot_d  = '1;
                rem_d   = dividend;
                dbz_d   = 1'b1;
            end else begin
                state_d = BUSY;
            end
        end
        if (state_q == BUSY) begin
            r_d   = r_nx;
            q_d   = q_nx;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d = DONE;
                quot_d  = q_fix;
                rem_d   = r_fix;
                dbz_d   = 1'b0;
            end
        end
    end

    // state, shift registers and registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= RST_FLAG;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with a result scoreboard checked by an independent monitor
module tb_seq_divider;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int   vectors = 0;
    int   miscompares = 0;
    res_t sb[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endtask

    // present one operand pair; elat < 0 skips the latency check
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                      input bit push, input int elat);
        int lat;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        chk("in_ready before accept", {31'd0, in_ready}, 1);
        if (push) sb.push_back('{eq, er, ez});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (elat >= 0) begin
            lat = 0;
            while (!out_valid && lat < 50) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk("latency edges after accept", lat, elat);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: every result taken by the consumer is matched against the scoreboard
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected result: q=%0d r=%0d z=%0d, expected none", quotient, remainder, div_by_zero);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", {28'd0, quotient}, {28'd0, e.q});
                    chk("remainder", {28'd0, remainder}, {28'd0, e.r});
                    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
                end
            end
        end
    end

    initial begin
        vec_t tbl[5];
`ifdef SEQ_DIVIDER_SIGNED_EN
        tbl[0] = '{4'd9,  4'd2,  4'd13, 4'd15, 1'b0};
        tbl[1] = '{4'd8,  4'd15, 4'd8,  4'd0,  1'b0};
        tbl[2] = '{4'd7,  4'd14, 4'd13, 4'd1,  1'b0};
        tbl[3] = '{4'd13, 4'd0,  4'd15, 4'd13, 1'b1};
        tbl[4] = '{4'd6,  4'd3,  4'd2,  4'd0,  1'b0};
`else
        tbl[0] = '{4'd0,  4'd5,  4'd0,  4'd0,  1'b0};
        tbl[1] = '{4'd3,  4'd7,  4'd0,  4'd3,  1'b0};
        tbl[2] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0};
        tbl[3] = '{4'd15, 4'd2,  4'd7,  4'd1,  1'b0};
        tbl[4] = '{4'd8,  4'd3,  4'd2,  4'd2,  1'b0};
`endif
        #12;
        chk("reset in_ready", {31'd0, in_ready}, 0);
        chk("reset out_valid", {31'd0, out_valid}, 0);
        chk("reset quotient", {28'd0, quotient}, 0);
        chk("reset remainder", {28'd0, remainder}, 0);
        chk("reset div_by_zero", {31'd0, div_by_zero}, 0);
        rst = 1'b0;
        step();

`ifdef SEQ_DIVIDER_SIGNED_EN
        op(4'd13, 4'd3, 4'd15, 4'd0, 1'b0, 1, W);
`else
        op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1, W);
`endif
        step();
        op(4'd7, 4'd0, 4'd15, 4'd7, 1'b1, 1, 0);
        step();

        out_ready = 1'b0;
        op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1, W);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            dividend = 4'd3;
            divisor  = 4'd1;
            step();
            chk("hold out_valid", {31'd0, out_valid}, 1);
            chk("hold in_ready", {31'd0, in_ready}, 0);
            chk("hold quotient", {28'd0, quotient}, 15);
            chk("hold remainder", {28'd0, remainder}, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("release out_valid", {31'd0, out_valid}, 0);
        chk("release quotient held", {28'd0, quotient}, 15);
        step();

`ifdef SEQ_DIVIDER_SIGNED_EN
        op(4'd9, 4'd2, 4'd13, 4'd15, 1'b0, 1, W);
        chk("b2b done before second", {31'd0, out_valid}, 1);
        op(4'd14, 4'd5, 4'd0, 4'd14, 1'b0, 1, W);
`else
        op(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1, W);
        chk("b2b done before second", {31'd0, out_valid}, 1);
        op(4'd14, 4'd5, 4'd2, 4'd4, 1'b0, 1, W);
`endif
        step();

        foreach (tbl[k]) begin
            op(tbl[k].a, tbl[k].b, tbl[k].q, tbl[k].r, tbl[k].z, 1, tbl[k].z ? 0 : W);
            step();
        end

        op(4'd11, 4'd2, 4'd0, 4'd0, 1'b0, 0, -1);
        step();
        rst = 1'b1;
        #1;
        chk("async reset in_ready", {31'd0, in_ready}, 0);
        chk("async reset out_valid", {31'd0, out_valid}, 0);
        chk("async reset quotient", {28'd0, quotient}, 0);
        chk("async reset remainder", {28'd0, remainder}, 0);
        chk("async reset div_by_zero", {31'd0, div_by_zero}, 0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("discarded op no output", {31'd0, out_valid}, 0);
        op(4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 1, W);
        for (int i = 0; i < 4; i++) step();
        chk("scoreboard drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
